frame_strobe_gen: RTL



---
 rtl/frame_strobe_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/frame_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module   : frame_strobe_gen
// Purpose  : Column-base frame write sequencer. Filters requests by column,
//            then runs each write as data setup -> one-hot strobe -> data hold.
// Revision : 1.0  initial release
// ============================================================================
module frame_strobe_gen #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int ColBits         = 5,
  parameter int ColumnId        = 0,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 1,
  parameter int HoldCycles      = 1
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ColBits-1:0]         req_col,
  input  logic [4:0]                 req_frame,
  input  logic [FrameBitsPerRow-1:0] req_data,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err_addr,
  output logic [15:0]                frames_written
);

  // Zero-length phases are stretched to one cycle.
  localparam int C_SETUP_N  = (SetupCycles  < 1) ? 1 : SetupCycles;
  localparam int C_STROBE_N = (StrobeCycles < 1) ? 1 : StrobeCycles;
  localparam int C_HOLD_N   = (HoldCycles   < 1) ? 1 : HoldCycles;
  localparam int C_MAX_A    = (C_SETUP_N > C_STROBE_N) ? C_SETUP_N : C_STROBE_N;
  localparam int C_MAX_N    = (C_MAX_A > C_HOLD_N) ? C_MAX_A : C_HOLD_N;
  localparam int C_CNT_W    = (C_MAX_N > 1) ? $clog2(C_MAX_N) : 1;

  localparam logic [C_CNT_W-1:0] C_SETUP_LD  = C_CNT_W'(C_SETUP_N - 1);
  localparam logic [C_CNT_W-1:0] C_STROBE_LD = C_CNT_W'(C_STROBE_N - 1);
  localparam logic [C_CNT_W-1:0] C_HOLD_LD   = C_CNT_W'(C_HOLD_N - 1);
  localparam logic [ColBits-1:0] C_COL_ID    = ColBits'(ColumnId);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [C_CNT_W-1:0]           cnt_q, cnt_d;
  logic [4:0]                   frame_q, frame_d;
  logic [FrameBitsPerRow-1:0]   data_q, data_d;
  logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
  logic                         err_q, err_d;
  logic [15:0]                  frames_written_q, frames_written_d;

  logic                         w_col_match;
  logic                         w_frame_ok;
  logic [MaxFramesPerCol-1:0]   w_onehot;

  assign w_col_match = (req_col == C_COL_ID);
  assign w_frame_ok  = (32'(req_frame) < MaxFramesPerCol);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      w_onehot[i] = (frame_q == 5'(i));
    end
  end

  // Strobe is computed from the next state so it leaves a flop with no decode.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    frame_d          = frame_q;
    data_d           = data_q;
    strobe_d         = '0;
    err_d            = err_q;
    frames_written_d = frames_written_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && w_col_match) begin
          if (w_frame_ok) begin
            data_d  = req_data;
            frame_d = req_frame;
            cnt_d   = C_SETUP_LD;
            state_d = S_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d    = C_STROBE_LD;
          state_d  = S_STROBE;
          strobe_d = w_onehot;
        end else begin
          cnt_d = cnt_q - C_CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          cnt_d            = C_HOLD_LD;
          state_d          = S_HOLD;
          frames_written_d = frames_written_q + 16'd1;
        end else begin
          cnt_d    = cnt_q - C_CNT_W'(1);
          strobe_d = w_onehot;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - C_CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      frame_q          <= '0;
      data_q           <= '0;
      strobe_q         <= '0;
      err_q            <= 1'b0;
      frames_written_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      frame_q          <= frame_d;
      data_q           <= data_d;
      strobe_q         <= strobe_d;
      err_q            <= err_d;
      frames_written_q <= frames_written_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE) && resetn;
  assign busy           = (state_q != S_IDLE);
  assign FrameData      = data_q;
  assign FrameStrobe    = strobe_q;
  assign err_addr       = err_q;
  assign frames_written = frames_written_q;

endmodule
`default_nettype wire
